// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic skew feeder.
//   DEFAULT_DATA_SIZE : default width of one Q8.8 element
//   DEFAULT_SIZE      : default lane count of the downstream array
//   FRAC_BITS         : fraction bits of the default Q8.8 element
//   feeder_state_t    : FSM state encoding (also exported on the debug port)
package systolic_skew_feeder_pkg;

    localparam int DEFAULT_DATA_SIZE = 16;
    localparam int DEFAULT_SIZE      = 3;
    localparam int FRAC_BITS         = DEFAULT_DATA_SIZE / 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } feeder_state_t;

    // Fraction bits of a Q(n/2).(n/2) element of the given width.
    function automatic int frac_bits_of(input int data_size);
        return data_size / 2;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_delay.sv
// skew_delay_line: fixed-latency register chain for one lane of the skew.
//   clk, rst_n : clock, asynchronous active-low reset (clears every stage)
//   din        : element injected this cycle
//   dout       : element injected depth cycles earlier
module skew_delay_line #(
    parameter int data_size = 16,
    parameter int depth     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [data_size-1:0] din,
    output logic [data_size-1:0] dout
);

    logic [data_size-1:0] stage [depth];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < depth; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[depth-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: turns a stream of whole A/B vectors into the
// diagonally skewed wavefront expected by continuous_systolic.
//   clk, rst_n     : clock, asynchronous active-low reset
//   in_a, in_b     : one vector per transfer, lane 0 in the MSB slice
//   in_valid       : source has a vector on in_a/in_b/in_last
//   in_last        : vector is the final one of a tile
//   in_ready       : feeder can take a vector this cycle
//   a, b           : skewed streams, lane k delayed k+1 cycles
//   reset_counter  : one-cycle pulse alongside lane 0 of a tile's first vector
//   tile_done      : one-cycle pulse on the first IDLE cycle after a flush
//   state_dbg      : current FSM state, for observation only
//
// Handshake: a vector is consumed on a rising edge where in_valid and
// in_ready are both 1; in_ready depends only on the state, never on in_valid.
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int data_size = DEFAULT_DATA_SIZE,
    parameter int size      = DEFAULT_SIZE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [data_size*size-1:0] in_a,
    input  logic [data_size*size-1:0] in_b,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [data_size*size-1:0] a,
    output logic [data_size*size-1:0] b,
    output logic                      reset_counter,
    output logic                      tile_done,
    output feeder_state_t             state_dbg
);

    // Cycles needed after the last vector for lane size-1 to drain its
    // wavefront through the array.
    localparam int FLUSH_LEN = 2 * size - 2;
    localparam int CNT_W     = $clog2(2 * size + 1);

    feeder_state_t    state, state_next;
    logic [CNT_W-1:0] flush_cnt, flush_cnt_next;
    logic [CNT_W-1:0] flush_inc;
    logic             reset_counter_next;
    logic             tile_done_next;
    logic             xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            flush_cnt     <= '0;
            reset_counter <= 1'b0;
            tile_done     <= 1'b0;
        end else begin
            state         <= state_next;
            flush_cnt     <= flush_cnt_next;
            reset_counter <= reset_counter_next;
            tile_done     <= tile_done_next;
        end
    end

    always_comb begin
        state_next         = state;
        flush_cnt_next     = flush_cnt;
        reset_counter_next = 1'b0;
        tile_done_next     = 1'b0;
        in_ready           = (state != ST_FLUSH);
        xfer               = in_valid && in_ready;
        flush_inc          = flush_cnt + 1'b1;

        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    // Registered so the pulse lines up with lane 0's register.
                    reset_counter_next = 1'b1;
                    state_next         = in_last ? ST_FLUSH : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (xfer && in_last) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // ">=" keeps size=1 (FLUSH_LEN=0) to a single FLUSH cycle.
                if (flush_inc >= CNT_W'(FLUSH_LEN)) begin
                    state_next     = ST_IDLE;
                    flush_cnt_next = '0;
                    tile_done_next = 1'b1;
                end else begin
                    flush_cnt_next = flush_inc;
                end
            end
            default: begin
                state_next     = ST_IDLE;
                flush_cnt_next = '0;
            end
        endcase
    end

    assign state_dbg = state;

    // Each lane injects its slice on a transfer and a zero bubble otherwise,
    // so the array keeps moving whether or not the source has data.
    for (genvar k = 0; k < size; k++) begin : g_lane
        logic [data_size-1:0] inj_a, inj_b;

        assign inj_a = xfer ? in_a[data_size*(size-k)-1 -: data_size] : '0;
        assign inj_b = xfer ? in_b[data_size*(size-k)-1 -: data_size] : '0;

        skew_delay_line #(
            .data_size (data_size),
            .depth     (k + 1)
        ) u_dl_a (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (inj_a),
            .dout (a[data_size*(size-k)-1 -: data_size])
        );

        skew_delay_line #(
            .data_size (data_size),
            .depth     (k + 1)
        ) u_dl_b (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (inj_b),
            .dout (b[data_size*(size-k)-1 -: data_size])
        );
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;
  import systolic_skew_feeder_pkg::*;

  localparam int DW = 16;
  localparam int N  = 3;
  localparam int W  = DW * N;
  localparam int EW = 2 * W + 2;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  in_a, in_b;
  logic          in_valid, in_last;
  logic          in_ready;
  logic [W-1:0]  a, b;
  logic          reset_counter, tile_done;
  feeder_state_t state_dbg;

  systolic_skew_feeder #(.data_size(DW), .size(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .reset_counter(reset_counter),
    .tile_done    (tile_done),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  hist_a [N];
  logic [W-1:0]  hist_b [N];
  int            n_checks = 0;
  int            n_err    = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < N; i++) begin
      hist_a[i] = '0;
      hist_b[i] = '0;
    end
  endtask

  // Monitor: every cycle following a driven step, pop and compare.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("a", a, e[EW-1 -: W]);
        check("b", b, e[W+1 -: W]);
        check("reset_counter", W'(reset_counter), W'(e[1]));
        check("tile_done", W'(tile_done), W'(e[0]));
      end
    end
  end

  // ---------------- driver ----------------
  // One clock step: inputs, hand-expected in_ready before the edge, and
  // hand-expected reset_counter / tile_done after it. Data expectations come
  // from a lane-k-delayed history of what the bench itself transferred.
  task automatic step(input logic v, input logic l, input logic [W-1:0] va,
                      input logic [W-1:0] vb, input logic exp_rdy,
                      input logic exp_rc, input logic exp_td);
    logic [W-1:0] ea, eb;
    logic         xfer;
    @(negedge clk);
    in_valid = v;
    in_last  = l;
    in_a     = va;
    in_b     = vb;
    #1;
    check("in_ready", W'(in_ready), W'(exp_rdy));
    xfer = v && exp_rdy;
    for (int i = N - 1; i > 0; i--) begin
      hist_a[i] = hist_a[i-1];
      hist_b[i] = hist_b[i-1];
    end
    hist_a[0] = xfer ? va : '0;
    hist_b[0] = xfer ? vb : '0;
    ea = '0;
    eb = '0;
    for (int k = 0; k < N; k++) begin
      ea[DW*(N-k)-1 -: DW] = hist_a[k][DW*(N-k)-1 -: DW];
      eb[DW*(N-k)-1 -: DW] = hist_b[k][DW*(N-k)-1 -: DW];
    end
    exp_q.push_back({ea, eb, exp_rc, exp_td});
  endtask

  // Four FLUSH cycles (size=3): in_ready low, tile_done after the fourth edge.
  task automatic flush4(input logic v, input logic [W-1:0] va, input logic [W-1:0] vb);
    step(v, 1'b0, va, vb, 1'b0, 1'b0, 1'b0);
    step(v, 1'b0, va, vb, 1'b0, 1'b0, 1'b0);
    step(v, 1'b0, va, vb, 1'b0, 1'b0, 1'b0);
    step(v, 1'b0, va, vb, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    check("rst_a", a, '0);
    check("rst_b", b, '0);
    check("rst_reset_counter", W'(reset_counter), '0);
    check("rst_tile_done", W'(tile_done), '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", W'(in_ready), W'(1));
    clear_hist();
  endtask

  localparam logic [W-1:0] A0 = {16'h0100, 16'h0200, 16'h0300};
  localparam logic [W-1:0] A1 = {16'h0400, 16'h0500, 16'h0600};
  localparam logic [W-1:0] A2 = {16'h0700, 16'h0800, 16'h0900};
  localparam logic [W-1:0] B0 = {16'h1000, 16'h2000, 16'h3000};
  localparam logic [W-1:0] B1 = {16'h4000, 16'h5000, 16'h6000};
  localparam logic [W-1:0] B2 = {16'h7000, 16'h8000, 16'h9000};
  localparam logic [W-1:0] S1 = {16'h0100, 16'h0100, 16'h0100};
  localparam logic [W-1:0] C0 = {16'hA001, 16'hB002, 16'hC003};
  localparam logic [W-1:0] C1 = {16'hFFFF, 16'h8000, 16'h7FFF};

  initial begin
    int wait_cycles;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = '0;
    in_b     = '0;
    clear_hist();
    repeat (2) @(posedge clk);
    do_reset();

    // Three-vector tile, then flush and one idle cycle.
    step(1'b1, 1'b0, A0, B0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, A1, B1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, A2, B2, 1'b1, 1'b0, 1'b0);
    flush4(1'b0, '0, '0);
    idle();

    // Bubble mid-tile: zero wavefront, no extra reset_counter.
    step(1'b1, 1'b0, A2, B1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, A0, B0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, A1, B2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, C0, C1, 1'b1, 1'b0, 1'b0);
    flush4(1'b0, '0, '0);
    idle();

    // Back-to-back tiles: source holds C1 valid through the flush.
    step(1'b1, 1'b0, A0, B0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, A1, B1, 1'b1, 1'b0, 1'b0);
    flush4(1'b1, C1, C0);
    step(1'b1, 1'b0, C1, C0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, A2, B2, 1'b1, 1'b0, 1'b0);
    flush4(1'b0, '0, '0);
    idle();

    // Single-vector tile.
    step(1'b1, 1'b1, S1, S1, 1'b1, 1'b1, 1'b0);
    flush4(1'b0, '0, '0);
    idle();

    // Reset mid-stream, then a fresh tile.
    step(1'b1, 1'b0, A0, B0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, A1, B1, 1'b1, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 1'b1, A2, B2, 1'b1, 1'b1, 1'b0);
    flush4(1'b0, '0, '0);
    idle();
    idle();

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 Parameter: data_size, default 16, width of one Q8.8 fixed-point element (data_size/2 fraction bits).
REQ-002 Parameter: size, default 3, number of lanes (array dimension) of the downstream continuous_systolic.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_a  input  data_size*size  one A vector; lane k at bits [data_size*(size-k)-1 -: data_size] (lane 0 = MSB slice).
REQ-006 in_b  input  data_size*size  one B vector, same lane packing.
REQ-007 in_valid  input  1  in_a/in_b/in_last valid.
REQ-008 in_last  input  1  marks final vector of a tile.
REQ-009 in_ready  output  1  feeder accepts a vector this cycle.
REQ-010 a  output  data_size*size  skewed A stream to continuous_systolic.a.
REQ-011 b  output  data_size*size  skewed B stream to continuous_systolic.b.
REQ-012 reset_counter  output  1  tile-start pulse to continuous_systolic.reset_counter.
REQ-013 tile_done  output  1  one-cycle pulse when a tile's flush completes.

Function
REQ-014 Transfer occurs on a rising edge with in_valid=1 and in_ready=1; no other cycle consumes input.
REQ-015 FSM states IDLE, STREAM, FLUSH; IDLE->STREAM on transfer with in_last=0; IDLE->FLUSH on transfer with in_last=1; STREAM->FLUSH on transfer with in_last=1; FLUSH->IDLE when flush counter reaches 2*size-2.
REQ-016 in_ready = 1 in IDLE and STREAM, 0 in FLUSH (combinational from state).
REQ-017 Lane-0 injection each cycle: transferred element if transfer, else zero (bubble); bubbles never stall the array.
REQ-018 Lane k element of a vector transferred at edge t appears on a and b at cycle t+1+k (lane k delay = k+1 registers).
REQ-019 reset_counter = 1 for exactly the cycle in which lane 0 of a tile's first vector is on the outputs (edge t+1 after the IDLE transfer); 0 otherwise.
REQ-020 Single-vector tile (in_last on first transfer) still produces the reset_counter pulse.
REQ-021 FLUSH counter counts 1..2*size-2 cycles after the in_last transfer, injecting zeros; tile_done pulses on the cycle the FSM returns to IDLE.
REQ-022 in_valid held high through FLUSH: no transfer; vector held by source is accepted in first IDLE cycle as a new tile's first vector.
REQ-023 Elements pass unmodified; no arithmetic, no saturation, no width change.
REQ-024 size=1 degenerate: no skew beyond one register; FLUSH lasts 0 cycles (IDLE->FLUSH->IDLE still one cycle, tile_done fires).

Reset
REQ-025 On rst_n=0 (asynchronous): state IDLE, flush counter 0, all delay registers 0, a=b=0, reset_counter=0, tile_done=0; in_ready reads 1 once rst_n=1.
REQ-026 Reset mid-STREAM or mid-FLUSH discards all in-flight data; first transfer after release starts a new tile with reset_counter pulse.

Structure
REQ-027 Shared package holds default data_size/size, FSM state encoding, Q8.8 fraction-bit constant (data_size/2).
REQ-028 One sub-module, skew_delay_line (parameters data_size, depth), instantiated twice per lane (A and B) with depth=k+1.

Verification
REQ-029 Reset: rst_n=0 mid-stream -> a=b=0, reset_counter=0, in_ready=1 immediately after release.
REQ-030 Tile of 3 vectors A rows {0x0100,0x0200,0x0300},{0x0400,0x0500,0x0600},{0x0700,0x0800,0x0900}, in_last on 3rd -> lane0 0x0100 at t+1, lane2 0x0300 at t+3, lane2 0x0900 at t+5; reset_counter only at t+1.
REQ-031 Flush: after in_last, in_ready=0 for 4 cycles (size=3), outputs zero once drained, tile_done one pulse, then in_ready=1.
REQ-032 Bubble: in_valid low one cycle mid-tile -> zero appears on each lane skewed by k; no reset_counter.
REQ-033 Back-to-back tiles with in_valid held through FLUSH -> second tile's first vector accepted in first IDLE cycle, second reset_counter pulse one cycle later.
REQ-034 Single-vector tile 0x0100 all lanes with in_last -> reset_counter pulse, lanes 0/1/2 show 0x0100 at t+1/t+2/t+3, tile_done after 4 flush cycles.
